// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: sync, pending latch, enable mask, one acknowledged winner at a time.
// Define IRQ_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module riscv_irq_arbiter #(
   parameter int                 NUM_SRC   = 4,
   parameter logic [4:0]         ID_BASE   = 5'd7,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
   parameter logic [NUM_SRC-1:0] EN_RST    = '1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               cfg_we_i,
   input  logic [NUM_SRC-1:0] cfg_wdata_i,
   output logic [NUM_SRC-1:0] cfg_en_o,
   output logic [NUM_SRC-1:0] pending_o,
   output logic               irq_o,
   output logic [4:0]         irq_id_o,
   input  logic               irq_ack_i,
   input  logic [4:0]         irq_id_i,
   output logic               ack_err_o
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] en_q, en_d;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] clr;
   logic [IW-1:0]      win_q, win_d, win_sel;
   logic [4:0]         id_q, id_d;
   logic               err_q, err_d;
   logic               ack_ok;

`ifdef IRQ_ARB_RR_EN
   logic [IW-1:0]      ptr_q, ptr_d;
`endif

   assign elig   = pend_q & en_q;
   assign ack_ok = irq_ack_i && (irq_id_i == id_q);

   // Descending scan so the first hit in search order is the one kept.
   always_comb begin
      win_sel = '0;
`ifdef IRQ_ARB_RR_EN
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (elig[(int'(ptr_q) + k) % NUM_SRC]) begin
            win_sel = IW'((int'(ptr_q) + k) % NUM_SRC);
         end
      end
`else
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_sel = IW'(i);
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      id_d    = id_q;
      err_d   = 1'b0;
      clr     = '0;
`ifdef IRQ_ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            err_d = irq_ack_i;
            if (|elig) begin
               win_d   = win_sel;
               id_d    = ID_BASE + 5'(win_sel);
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_ok) begin
               clr[win_q] = 1'b1;
`ifdef IRQ_ARB_RR_EN
               ptr_d = (int'(win_q) == NUM_SRC - 1) ? '0 : win_q + 1'b1;
`endif
               state_d = GAP;
            end else begin
               err_d = irq_ack_i;
               if (!elig[win_q]) begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            err_d   = irq_ack_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A fresh rising edge beats a same-cycle clear.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (EDGE_MASK[i]) begin
            pend_d[i] = (pend_q[i] & ~clr[i]) | (s2_q[i] & ~s3_q[i]);
         end else begin
            pend_d[i] = s2_q[i];
         end
      end
   end

   assign en_d = cfg_we_i ? cfg_wdata_i : en_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         pend_q  <= '0;
         en_q    <= EN_RST;
         state_q <= IDLE;
         win_q   <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         s1_q    <= src_i;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pend_q  <= pend_d;
         en_q    <= en_d;
         state_q <= state_d;
         win_q   <= win_d;
         id_q    <= id_d;
         err_q   <= err_d;
      end
   end

`ifdef IRQ_ARB_RR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign cfg_en_o  = en_q;
   assign pending_o = pend_q;
   assign irq_o     = (state_q == REQ);
   assign irq_id_o  = id_q;
   assign ack_err_o = err_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Scoreboard bench for riscv_irq_arbiter; sources 0-2 edge, source 3 level.
// Expected ids are queued when a source is raised and popped when irq_o rises.
module tb_riscv_irq_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src_i;
   logic       cfg_we_i;
   logic [3:0] cfg_wdata_i;
   logic [3:0] cfg_en_o;
   logic [3:0] pending_o;
   logic       irq_o;
   logic [4:0] irq_id_o;
   logic       irq_ack_i;
   logic [4:0] irq_id_i;
   logic       ack_err_o;

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   riscv_irq_arbiter #(
      .NUM_SRC  (4),
      .ID_BASE  (5'd7),
      .EDGE_MASK(4'b0111),
      .EN_RST   (4'b1111)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .src_i      (src_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_wdata_i(cfg_wdata_i),
      .cfg_en_o   (cfg_en_o),
      .pending_o  (pending_o),
      .irq_o      (irq_o),
      .irq_id_o   (irq_id_o),
      .irq_ack_i  (irq_ack_i),
      .irq_id_i   (irq_id_i),
      .ack_err_o  (ack_err_o)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_irq(input string tag);
      int   n;
      logic [4:0] e;
      n = 0;
      while (!irq_o && n < 20) begin
         step();
         n++;
      end
      check({tag, "_irq"}, irq_o, 1'b1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_id"}, irq_id_o, e);
      end
   endtask

   task automatic wait_low(input string tag);
      int n;
      n = 0;
      while (irq_o && n < 20) begin
         step();
         n++;
      end
      check({tag, "_low"}, irq_o, 1'b0);
   endtask

   task automatic ack(input logic [4:0] id);
      irq_ack_i = 1'b1;
      irq_id_i  = id;
      step();
      irq_ack_i = 1'b0;
      irq_id_i  = '0;
   endtask

   initial begin
      rst         = 1'b1;
      src_i       = '0;
      cfg_we_i    = 1'b0;
      cfg_wdata_i = '0;
      irq_ack_i   = 1'b0;
      irq_id_i    = '0;
      step(2);
      check("rst_irq", irq_o, 1'b0);
      check("rst_en", cfg_en_o, 4'hF);
      check("rst_pend", pending_o, 4'h0);
      rst = 1'b0;
      step();

      // single edge on source 1
      src_i[1] = 1'b1;
      exp_q.push_back(5'd8);
      step(2);
      check("lat_pend_early", pending_o[1], 1'b0);
      step();
      check("lat_pend", pending_o[1], 1'b1);
      check("lat_irq_early", irq_o, 1'b0);
      step();
      check("lat_irq", irq_o, 1'b1);
      wait_irq("single");
      ack(5'd8);
      check("single_gap", irq_o, 1'b0);
      check("single_clr", pending_o[1], 1'b0);
      check("single_noerr", ack_err_o, 1'b0);
      src_i[1] = 1'b0;
      step(4);

      // two sources rise together
`ifdef IRQ_ARB_RR_EN
      exp_q.push_back(5'd9);
      exp_q.push_back(5'd7);
`else
      exp_q.push_back(5'd7);
      exp_q.push_back(5'd9);
`endif
      src_i[0] = 1'b1;
      src_i[2] = 1'b1;
      wait_irq("prio1");
      ack(irq_id_o);
      check("prio_gap", irq_o, 1'b0);
      wait_irq("prio2");
      ack(irq_id_o);
      check("prio_pend", pending_o, 4'h0);
      src_i = '0;
      step(4);

      // bad ack keeps request
      src_i[0] = 1'b1;
      exp_q.push_back(5'd7);
      wait_irq("badack");
      ack(5'd11);
      check("badack_err", ack_err_o, 1'b1);
      check("badack_irq", irq_o, 1'b1);
      check("badack_pend", pending_o[0], 1'b1);
      step();
      check("badack_pulse", ack_err_o, 1'b0);
      check("badack_id", irq_id_o, 5'd7);
      ack(5'd7);
      check("goodack_err", ack_err_o, 1'b0);
      step(2);
      ack(5'd9);
      check("idleack_err", ack_err_o, 1'b1);
      check("idleack_irq", irq_o, 1'b0);
      src_i[0] = 1'b0;
      step(4);

      // level source withdrawn by the line
      src_i[3] = 1'b1;
      exp_q.push_back(5'd10);
      wait_irq("lvl");
      src_i[3] = 1'b0;
      wait_low("lvl_drop");
      check("lvl_pend", pending_o[3], 1'b0);
      step(3);

      // level source withdrawn by masking
      src_i[3] = 1'b1;
      exp_q.push_back(5'd10);
      wait_irq("mask");
      cfg_we_i    = 1'b1;
      cfg_wdata_i = 4'b0111;
      step();
      cfg_we_i = 1'b0;
      check("mask_en", cfg_en_o, 4'b0111);
      wait_low("mask");
      check("mask_pend", pending_o[3], 1'b1);
      src_i[3] = 1'b0;
      step(5);
      cfg_we_i    = 1'b1;
      cfg_wdata_i = 4'hF;
      step();
      cfg_we_i = 1'b0;
      check("mask_restore", cfg_en_o, 4'hF);

      // new edge coincides with clearing ack
      src_i[0] = 1'b1;
      exp_q.push_back(5'd7);
      wait_irq("coll_a");
      src_i[0] = 1'b0;
      step(4);
      check("coll_hold", irq_o, 1'b1);
      src_i[0] = 1'b1;
      exp_q.push_back(5'd7);
      step(2);
      ack(5'd7);
      check("coll_gap", irq_o, 1'b0);
      check("coll_pend", pending_o[0], 1'b1);
      wait_irq("coll_b");
      ack(5'd7);
      check("coll_clr", pending_o[0], 1'b0);
      src_i[0] = 1'b0;
      step(4);

      // async reset mid-request
      cfg_we_i    = 1'b1;
      cfg_wdata_i = 4'b0101;
      step();
      cfg_we_i = 1'b0;
      src_i[2] = 1'b1;
      exp_q.push_back(5'd9);
      wait_irq("rstmid");
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_irq", irq_o, 1'b0);
      check("rstmid_id", irq_id_o, 5'd0);
      check("rstmid_pend", pending_o, 4'h0);
      check("rstmid_en", cfg_en_o, 4'hF);
      check("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
